// File: rtl/int_stream_unpacker_if.sv
// int_stream_unpacker_if: packed-word input stream and extended-element output stream of the unpacker
interface int_stream_unpacker_if #(parameter int CNT_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic [1:0]       in_kind;
  logic             in_unsigned;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic             out_last;
  logic [CNT_W-1:0] elem_count;
  modport slave (
    input  in_valid, in_data, in_kind, in_unsigned, out_ready,
    output in_ready, out_valid, out_data, out_last, elem_count
  );
  modport master (
    output in_valid, in_data, in_kind, in_unsigned, out_ready,
    input  in_ready, out_valid, out_data, out_last, elem_count
  );
endinterface

// File: rtl/int_stream_unpacker.sv
// int_stream_unpacker: splits 64-bit words into byte/shortint/int/longint elements, LSB-first, sign- or zero-extended
module int_stream_unpacker #(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  int_stream_unpacker_if.slave bus
);
  typedef enum logic {EMPTY, HOLD} state_t;
  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [63:0]      word_q, word_d;
  logic [1:0]       kind_q, kind_d;
  logic             uns_q, uns_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy, acc, hand, last;
  logic [2:0]       last_idx;
  logic [8:0]       sh_amt;
  logic [63:0]      sh, elem;
  always_comb begin
    busy     = state_q == HOLD;
    last_idx = 3'd7 >> kind_q;
    last     = busy && idx_q == last_idx;
    // bit offset of element idx is idx * (8 << kind)
    sh_amt   = {6'd0, idx_q} << ({1'b0, kind_q} + 3'd3);
    sh       = word_q >> sh_amt;
    elem     = kind_q == 2'd0 ? {{56{~uns_q & sh[7]}}, sh[7:0]} :
               kind_q == 2'd1 ? {{48{~uns_q & sh[15]}}, sh[15:0]} :
               kind_q == 2'd2 ? {{32{~uns_q & sh[31]}}, sh[31:0]} : sh;
    bus.out_valid  = busy;
    bus.out_last   = last;
    bus.out_data   = busy ? elem : 64'd0;
    bus.in_ready   = !busy || (last && bus.out_ready);
    bus.elem_count = cnt_q;
    hand    = busy && bus.out_ready;
    acc     = bus.in_valid && bus.in_ready;
    state_d = acc ? HOLD : (hand && last) ? EMPTY : state_q;
    idx_d   = acc ? 3'd0 : hand ? idx_q + 3'd1 : idx_q;
    word_d  = acc ? bus.in_data : word_q;
    kind_d  = acc ? bus.in_kind : kind_q;
    uns_d   = acc ? bus.in_unsigned : uns_q;
    cnt_d   = hand ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      word_q  <= '0;
      kind_q  <= '0;
      uns_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      kind_q  <= kind_d;
      uns_q   <= uns_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_int_stream_unpacker.sv
// tb_int_stream_unpacker: directed vectors with hand-computed elements for int_stream_unpacker
module tb_int_stream_unpacker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int_stream_unpacker_if #(.CNT_W(16)) bus ();
  int_stream_unpacker #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [63:0] d, input logic [1:0] k, input logic u);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_kind = k; bus.in_unsigned = u;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic elem(input string tag, input logic [63:0] exp, input logic lst);
    chk({tag, " valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, " data"}, bus.out_data, exp);
    chk({tag, " last"}, 64'(bus.out_last), 64'(lst));
    @(negedge clk);
  endtask
  task automatic idle(input string tag, input logic [15:0] cnt);
    chk({tag, " valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, " data"}, bus.out_data, 64'd0);
    chk({tag, " ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, " count"}, 64'(bus.elem_count), 64'(cnt));
  endtask
  logic [63:0] exp_b[8] = '{64'hFFFF_FFFF_FFFF_FFEF, 64'hFFFF_FFFF_FFFF_FFCD, 64'hFFFF_FFFF_FFFF_FFAB,
                            64'hFFFF_FFFF_FFFF_FF89, 64'h67, 64'h45, 64'h23, 64'h01};
  logic [63:0] exp_s[4] = '{64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF, 64'hFFFF_FFFF_FFFF_8000};
  logic [63:0] exp_p[4] = '{64'hFFFF_FFFF_FFFF_DEF0, 64'hFFFF_FFFF_FFFF_9ABC, 64'h5678, 64'h1234};
  logic [63:0] exp_u[8] = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55, 64'h66, 64'h77, 64'h88};
  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_kind = '0; bus.in_unsigned = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    idle("reset", 16'd0);
    chk("reset last", 64'(bus.out_last), 64'd0);
    send(64'h0123_4567_89AB_CDEF, 2'd0, 1'b0);
    for (int i = 0; i < 8; i++) elem($sformatf("byte%0d", i), exp_b[i], i == 7);
    idle("byte end", 16'd8);
    send(64'h0123_4567_89AB_CDEF, 2'd2, 1'b1);
    elem("int0", 64'h89AB_CDEF, 1'b0);
    elem("int1", 64'h0123_4567, 1'b1);
    idle("int end", 16'd10);
    send(64'h8000_7FFF_FFFF_0001, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) elem($sformatf("short%0d", i), exp_s[i], i == 3);
    idle("short end", 16'd14);
    bus.out_ready = 1'b0;
    send(64'h1234_5678_9ABC_DEF0, 2'd1, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 64'hDEAD_BEEF_0000_0000; bus.in_kind = 2'd3; bus.in_unsigned = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", 64'(bus.out_valid), 64'd1);
      chk("bp data", bus.out_data, exp_p[0]);
      chk("bp last", 64'(bus.out_last), 64'd0);
      chk("bp in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp count", 64'(bus.elem_count), 64'd14);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) elem($sformatf("bp%0d", i), exp_p[i], i == 3);
    idle("bp end", 16'd18);
    bus.in_valid = 1'b1; bus.in_data = 64'h1; bus.in_kind = 2'd3; bus.in_unsigned = 1'b0;
    chk("b2b ready0", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    chk("b2b ready1", 64'(bus.in_ready), 64'd1);
    bus.in_data = 64'hFFFF_FFFF_FFFF_FFFE;
    elem("b2b A", 64'h1, 1'b1);
    chk("b2b ready2", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b0;
    elem("b2b B", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    idle("b2b end", 16'd20);
    send(64'h8877_6655_4433_2211, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) elem($sformatf("pre%0d", i), exp_u[i], 1'b0);
    chk("pre count", 64'(bus.elem_count), 64'd23);
    rst = 1'b1;
    #1;
    idle("midrst", 16'd0);
    chk("midrst last", 64'(bus.out_last), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    idle("postrst", 16'd0);
    send(64'h8877_6655_4433_2211, 2'd0, 1'b1);
    for (int i = 0; i < 8; i++) elem($sformatf("post%0d", i), exp_u[i], i == 7);
    idle("post end", 16'd8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
